// File: rtl/bbx_pkg.sv
// Shared coordinate/box types and the grid, clamp and subsample helpers
// used by the bounding-box scoreboard.
package bbx_pkg;

    localparam int unsigned COORD_W   = 24;
    localparam int unsigned CNT_W_DEF = 32;
    localparam int unsigned SH_W      = 5;

    typedef logic signed [COORD_W-1:0]     coord_t;
    typedef logic [1:0][1:0][COORD_W-1:0]  box_t;

    typedef struct packed {
        logic in_valid;
        logic exp_valid;
        box_t box;
    } stage_t;

    // Lowest set bit wins when the mode is not one-hot; such cycles are flagged elsewhere.
    function automatic logic [1:0] ss_decode(input logic [3:0] ss);
        logic [1:0] lg2;
        lg2 = 2'd0;
        if (ss[0])      lg2 = 2'd3;
        else if (ss[1]) lg2 = 2'd2;
        else if (ss[2]) lg2 = 2'd1;
        return lg2;
    endfunction

    function automatic coord_t grid_floor(input coord_t v, input logic [SH_W-1:0] sh);
        coord_t mask;
        mask = ~((coord_t'(1) << sh) - coord_t'(1));
        return v & mask;
    endfunction

    function automatic coord_t clamp_lo(input coord_t v);
        return (v < coord_t'(0)) ? coord_t'(0) : v;
    endfunction

    function automatic coord_t clamp_hi(input coord_t v, input coord_t lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/bbx_ref.sv
// Combinational golden bounding box for one triangle: min/max, grid floor,
// screen clamp and degenerate-box rejection.
module bbx_ref
    import bbx_pkg::*;
#(
    parameter int unsigned RADIX = 10,
    parameter int unsigned VERTS = 3,
    parameter int unsigned AXIS  = 3
) (
    input  logic [VERTS-1:0][AXIS-1:0][COORD_W-1:0] verts,
    input  logic [1:0][COORD_W-1:0]                 screen,
    input  logic [1:0]                              ss_w_lg2,
    input  logic                                    in_valid,
    output box_t                                    box_c,
    output logic                                    valid_c
);

    coord_t lo_x, lo_y, hi_x, hi_y;
    coord_t ll_x, ll_y, ur_x, ur_y;
    logic [SH_W-1:0] sh;
    logic unused_bits;

    // Only x and y take part; z is carried through the port untouched.
    assign unused_bits = ^verts;

    always_comb begin
        lo_x = coord_t'(verts[0][0]);
        hi_x = lo_x;
        lo_y = coord_t'(verts[0][1]);
        hi_y = lo_y;
        for (int v = 1; v < VERTS; v++) begin
            if (coord_t'(verts[v][0]) < lo_x) lo_x = coord_t'(verts[v][0]);
            if (coord_t'(verts[v][0]) > hi_x) hi_x = coord_t'(verts[v][0]);
            if (coord_t'(verts[v][1]) < lo_y) lo_y = coord_t'(verts[v][1]);
            if (coord_t'(verts[v][1]) > hi_y) hi_y = coord_t'(verts[v][1]);
        end
        sh   = SH_W'(RADIX) - SH_W'(ss_w_lg2);
        ll_x = clamp_lo(grid_floor(lo_x, sh));
        ll_y = clamp_lo(grid_floor(lo_y, sh));
        ur_x = clamp_hi(grid_floor(hi_x, sh), coord_t'(screen[0]));
        ur_y = clamp_hi(grid_floor(hi_y, sh), coord_t'(screen[1]));
        box_c[0][0] = ll_x;
        box_c[0][1] = ll_y;
        box_c[1][0] = ur_x;
        box_c[1][1] = ur_y;
        valid_c = in_valid && (ur_x >= ll_x) && (ur_y >= ll_y);
    end

endmodule

// File: rtl/bbx_chk.sv
// Bounding-box scoreboard: reference box per lane, halt-aware delay line,
// compare against the DUT at R13, saturating counters and first-mismatch capture.
// Define BBX_CHK_FATAL_EN to stop simulation on the first detected error.
module bbx_chk
    import bbx_pkg::*;
#(
    parameter int unsigned SIGFIG     = COORD_W,
    parameter int unsigned RADIX      = 10,
    parameter int unsigned VERTS      = 3,
    parameter int unsigned AXIS       = 3,
    parameter int unsigned LANES      = 1,
    parameter int unsigned PIPE_DEPTH = 3,
    parameter int unsigned CNT_W      = CNT_W_DEF
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        halt_RnnnnL,
    input  logic [1:0][SIGFIG-1:0]                      screen_RnnnnS,
    input  logic [3:0]                                  subSample_RnnnnU,
    input  logic [LANES-1:0][VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R10S,
    input  logic [LANES-1:0]                            validTri_R10H,
    input  logic [LANES-1:0][1:0][1:0][SIGFIG-1:0]      box_R13S,
    input  logic [LANES-1:0]                            validTri_R13H,
    output logic [CNT_W-1:0]                            check_cnt,
    output logic [CNT_W-1:0]                            err_cnt,
    output logic [CNT_W-1:0]                            miss_cnt,
    output logic [CNT_W-1:0]                            spur_cnt,
    output logic                                        err_sticky,
    output logic                                        cfg_err,
    output logic [$clog2(LANES):0]                      first_lane,
    output logic [1:0][1:0][SIGFIG-1:0]                 first_exp_box,
    output logic [1:0][1:0][SIGFIG-1:0]                 first_got_box
);

    localparam int unsigned FL_W  = $clog2(LANES) + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    if (SIGFIG != COORD_W) begin : g_bad_sigfig
        $error("bbx_chk: SIGFIG must match bbx_pkg::COORD_W");
    end
    if (PIPE_DEPTH < 1) begin : g_bad_depth
        $error("bbx_chk: PIPE_DEPTH must be at least 1");
    end

    logic [1:0]       ss_w_lg2;
    logic             qual_c, cfg_bad_c;
    box_t             ref_box [LANES];
    logic [LANES-1:0] ref_valid;
    stage_t           pipe [LANES][PIPE_DEPTH];
    logic [LANES-1:0] chk_v, err_v, miss_v, spur_v;
    logic [FL_W-1:0]  hit_lane_c;
    box_t             hit_exp_c, hit_got_c;
    logic             first_seen;

    assign ss_w_lg2  = ss_decode(subSample_RnnnnU);
    assign cfg_bad_c = halt_RnnnnL && !$onehot(subSample_RnnnnU);
    assign qual_c    = halt_RnnnnL && $onehot(subSample_RnnnnU);

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        bbx_ref #(.RADIX(RADIX), .VERTS(VERTS), .AXIS(AXIS)) u_ref (
            .verts    (tri_R10S[l]),
            .screen   (screen_RnnnnS),
            .ss_w_lg2 (ss_w_lg2),
            .in_valid (validTri_R10H[l]),
            .box_c    (ref_box[l]),
            .valid_c  (ref_valid[l])
        );
    end

    // Delay line advances only on enabled cycles so it tracks the DUT pipeline.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int l = 0; l < LANES; l++)
                for (int s = 0; s < PIPE_DEPTH; s++)
                    pipe[l][s] <= '0;
        end else if (halt_RnnnnL) begin
            for (int l = 0; l < LANES; l++) begin
                pipe[l][0] <= '{in_valid: validTri_R10H[l], exp_valid: ref_valid[l], box: ref_box[l]};
                for (int s = 1; s < PIPE_DEPTH; s++)
                    pipe[l][s] <= pipe[l][s-1];
            end
        end
    end

    // Per-lane compare outcomes; the descending scan leaves the lowest mismatching lane.
    always_comb begin
        chk_v      = '0;
        err_v      = '0;
        miss_v     = '0;
        spur_v     = '0;
        hit_lane_c = '0;
        hit_exp_c  = '0;
        hit_got_c  = '0;
        for (int l = 0; l < LANES; l++) begin
            chk_v[l]  = qual_c && pipe[l][PIPE_DEPTH-1].in_valid;
            err_v[l]  = chk_v[l] && pipe[l][PIPE_DEPTH-1].exp_valid && validTri_R13H[l]
                        && (pipe[l][PIPE_DEPTH-1].box != box_t'(box_R13S[l]));
            miss_v[l] = chk_v[l] && pipe[l][PIPE_DEPTH-1].exp_valid && !validTri_R13H[l];
            spur_v[l] = chk_v[l] && !pipe[l][PIPE_DEPTH-1].exp_valid && validTri_R13H[l];
        end
        for (int l = int'(LANES) - 1; l >= 0; l--) begin
            if (err_v[l]) begin
                hit_lane_c = FL_W'(l);
                hit_exp_c  = pipe[l][PIPE_DEPTH-1].box;
                hit_got_c  = box_t'(box_R13S[l]);
            end
        end
    end

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                                 input logic [LANES-1:0] hits);
        logic [SUM_W-1:0] sum;
        sum = {1'b0, cnt} + SUM_W'($countones(hits));
        return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            check_cnt     <= '0;
            err_cnt       <= '0;
            miss_cnt      <= '0;
            spur_cnt      <= '0;
            err_sticky    <= 1'b0;
            cfg_err       <= 1'b0;
            first_seen    <= 1'b0;
            first_lane    <= '0;
            first_exp_box <= '0;
            first_got_box <= '0;
        end else begin
            check_cnt <= sat_add(check_cnt, chk_v);
            err_cnt   <= sat_add(err_cnt, err_v);
            miss_cnt  <= sat_add(miss_cnt, miss_v);
            spur_cnt  <= sat_add(spur_cnt, spur_v);
            if (cfg_bad_c)
                cfg_err <= 1'b1;
            if (cfg_bad_c || (|{err_v, miss_v, spur_v}))
                err_sticky <= 1'b1;
            if (!first_seen && (|err_v)) begin
                first_seen    <= 1'b1;
                first_lane    <= hit_lane_c;
                first_exp_box <= hit_exp_c;
                first_got_box <= hit_got_c;
            end
        end
    end

`ifdef BBX_CHK_FATAL_EN
    always @(posedge clk) begin
        if (rst && cfg_bad_c)
            $error("bbx_chk: non-one-hot subsample %b", subSample_RnnnnU);
        for (int l = 0; l < LANES; l++)
            if (rst && (err_v[l] || miss_v[l] || spur_v[l]))
                $error("bbx_chk: lane %0d exp_valid=%0b got_valid=%0b exp=%h got=%h", l,
                       pipe[l][PIPE_DEPTH-1].exp_valid, validTri_R13H[l],
                       pipe[l][PIPE_DEPTH-1].box, box_R13S[l]);
        if (rst && (cfg_bad_c || (|{err_v, miss_v, spur_v})))
            $finish;
    end
`else
    final begin
        $display("bbx_chk: checks=%0d box_err=%0d missing=%0d spurious=%0d cfg_err=%0b",
                 check_cnt, err_cnt, miss_cnt, spur_cnt, cfg_err);
    end
`endif

endmodule
